// File: rtl/countdown_timer_n.sv
// rtl/countdown_timer_n.sv - N-digit BCD set/countdown timer with multiplexed 7-segment display
//
// Purpose:
//   SET mode edits the value one digit at a time. Starting a nonzero value
//   enters RUN, which decrements the value once per TICK_DIV cycles. PAUSE
//   can resume or abort to SET. DONE blinks zeros until it is acknowledged
//   or until DONE_HOLD cycles have passed.
//   The display scans one digit per cycle. seg_sel and seg_dat are registered
//   together, so they always describe the same digit.
//
// Optional feature (macro TIMER_COUNTUP_EN):
//   Adds the dir_up input, which is sampled on the SET->RUN edge. In count-up
//   mode the programmed value becomes the target and the display counts up
//   from zero. The decimal point of the rightmost digit is lit in RUN/PAUSE.
//
// Ports:
//   clk_1khz  in   1           system clock, 1 kHz
//   nRst      in   1           synchronous active-low reset
//   inc_p     in   1           pulse: increment edited digit / acknowledge DONE
//   next_p    in   1           pulse: next edit position, start, abort, acknowledge
//   pause_p   in   1           pulse: pause, resume, acknowledge DONE
//   dir_up    in   1           (TIMER_COUNTUP_EN only) 1 = count up to target
//   seg_dat   out  8           segment pattern, bit7 = decimal point, active-high
//   seg_sel   out  NUM_DIGITS  one-cold digit enable, digit i on seg_sel[NUM_DIGITS-1-i]
//   edit_idx  out  clog2(N)    digit being edited (0 = leftmost)
//   running   out  1           high in RUN
//   done      out  1           high in DONE

module countdown_timer_n #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100,
  parameter int BLINK_HALF = 50,
  parameter int DONE_HOLD  = 2000
) (
  input  logic                          clk_1khz,
  input  logic                          nRst,
  input  logic                          inc_p,
  input  logic                          next_p,
  input  logic                          pause_p,
`ifdef TIMER_COUNTUP_EN
  input  logic                          dir_up,
`endif
  output logic [7:0]                    seg_dat,
  output logic [NUM_DIGITS-1:0]         seg_sel,
  output logic [$clog2(NUM_DIGITS)-1:0] edit_idx,
  output logic                          running,
  output logic                          done
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int VAL_W   = 4 * NUM_DIGITS;
  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLINK_W = $clog2(2 * BLINK_HALF);
  localparam int HOLD_W  = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TICK_W-1:0]     TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0]    BLINK_LAST = BLINK_W'(2 * BLINK_HALF - 1);
  localparam logic [BLINK_W-1:0]    BLINK_ON   = BLINK_W'(BLINK_HALF);
  localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(DONE_HOLD - 1);
  localparam logic [VAL_W-1:0]      NIB_MASK   = VAL_W'(4'hF);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);

  localparam logic [1:0] ST_SET   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // The value is one packed BCD word: digit 0 (leftmost) sits in the top
  // nibble, so the word reads like the displayed number in hex.
  logic [1:0]            state_q, state_d;
  logic [VAL_W-1:0]      val_q, val_d;
  logic [IDX_W-1:0]      edit_q, edit_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [BLINK_W-1:0]    blink_q, blink_d;
  logic [IDX_W-1:0]      scan_q, scan_d;
  logic [NUM_DIGITS-1:0] seg_sel_q, sel_d;
  logic [7:0]            seg_dat_q, pat_d;
  logic                  running_q, done_q;

  logic [3:0]            dig_cur, dig_new, scan_dig;
  logic [VAL_W-1:0]      val_inc, val_step;
  logic                  reached, blink_on;

`ifdef TIMER_COUNTUP_EN
  logic [VAL_W-1:0]      target_q, target_d;
  logic                  up_q, up_d;
`endif

  // Bit offset of digit idx inside the packed value word.
  function automatic logic [IDX_W+1:0] dig_shift(input logic [IDX_W-1:0] idx);
    return {LAST_IDX - idx, 2'b00};
  endfunction

  function automatic logic [3:0] get_dig(input logic [VAL_W-1:0] v,
                                         input logic [IDX_W-1:0] idx);
    logic [VAL_W-1:0] t;
    t = v >> dig_shift(idx);
    return t[3:0];
  endfunction

  function automatic logic [VAL_W-1:0] set_dig(input logic [VAL_W-1:0] v,
                                               input logic [IDX_W-1:0] idx,
                                               input logic [3:0]       d);
    logic [VAL_W-1:0] dw;
    dw = {{(VAL_W-4){1'b0}}, d};
    return (v & ~(NIB_MASK << dig_shift(idx))) | (dw << dig_shift(idx));
  endfunction

  // Walks the digits from the rightmost one, rotating each result into the
  // top of r, so after NUM_DIGITS steps r is back in display order.
  function automatic logic [VAL_W-1:0] bcd_dec(input logic [VAL_W-1:0] v);
    logic [VAL_W-1:0] w;
    logic [VAL_W-1:0] r;
    logic             borrow;
    logic [3:0]       d;
    w      = v;
    r      = '0;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = w[3:0];
      if (borrow) begin
        if (d == 4'd0) begin
          d = 4'd9;
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r = {d, r[VAL_W-1:4]};
      w = w >> 4;
    end
    return r;
  endfunction

`ifdef TIMER_COUNTUP_EN
  function automatic logic [VAL_W-1:0] bcd_inc(input logic [VAL_W-1:0] v);
    logic [VAL_W-1:0] w;
    logic [VAL_W-1:0] r;
    logic             carry;
    logic [3:0]       d;
    w     = v;
    r     = '0;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = w[3:0];
      if (carry) begin
        if (d == 4'd9) begin
          d = 4'd0;
        end else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end
      r = {d, r[VAL_W-1:4]};
      w = w >> 4;
    end
    return r;
  endfunction
`endif

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h67;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Control state machine
  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    edit_d   = edit_q;
    tick_d   = tick_q;
    hold_d   = '0;
    dig_cur  = get_dig(val_q, edit_q);
    dig_new  = (dig_cur == 4'd9) ? 4'd0 : dig_cur + 4'd1;
    val_inc  = inc_p ? set_dig(val_q, edit_q, dig_new) : val_q;
    val_step = bcd_dec(val_q);
    reached  = (val_step == '0);
`ifdef TIMER_COUNTUP_EN
    target_d = target_q;
    up_d     = up_q;
    if (up_q) begin
      val_step = bcd_inc(val_q);
      reached  = (val_step == target_q);
    end
`endif

    case (state_q)
      ST_SET: begin
        // Keeping tick at zero here means RUN always starts a full period.
        tick_d = '0;
        // The increment is applied before next_p so the start check sees it.
        val_d  = val_inc;
        if (next_p) begin
          if (edit_q != LAST_IDX) begin
            edit_d = edit_q + 1'b1;
          end else begin
            edit_d = '0;
            if (val_inc != '0) begin
              state_d = ST_RUN;
`ifdef TIMER_COUNTUP_EN
              up_d = dir_up;
              if (dir_up) begin
                target_d = val_inc;
                val_d    = '0;
              end
`endif
            end
          end
        end
      end

      ST_RUN: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          val_d  = val_step;
          if (reached) begin
            state_d = ST_DONE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
        // Expiry on the same edge takes precedence over pausing.
        if (pause_p && (state_d == ST_RUN)) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (pause_p) begin
          state_d = ST_RUN;
        end else if (next_p) begin
          state_d = ST_SET;
          edit_d  = '0;
        end
      end

      ST_DONE: begin
        if (inc_p || next_p || pause_p || (hold_q == HOLD_LAST)) begin
          state_d = ST_SET;
          val_d   = '0;
          edit_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_SET;
      end
    endcase
  end

  // Display scan and blanking
  always_comb begin
    blink_d  = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
    scan_d   = (scan_q == LAST_IDX) ? '0 : scan_q + 1'b1;
    blink_on = (blink_q < BLINK_ON);
    scan_dig = get_dig(val_q, scan_q);
    pat_d    = seg_code(scan_dig);
    sel_d    = ~(SEL_ONE << (LAST_IDX - scan_q));

    case (state_q)
      ST_SET: begin
        if ((scan_q == edit_q) && !blink_on) begin
          pat_d = 8'h00;
        end
      end
      ST_PAUSE: begin
        if (!blink_on) begin
          pat_d = 8'h00;
        end
      end
      ST_DONE: begin
        pat_d = blink_on ? seg_code(4'd0) : 8'h00;
      end
      default: begin
      end
    endcase

`ifdef TIMER_COUNTUP_EN
    if (up_q && ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && (scan_q == LAST_IDX)) begin
      pat_d[7] = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_1khz) begin
    if (!nRst) begin
      state_q   <= ST_SET;
      val_q     <= '0;
      edit_q    <= '0;
      tick_q    <= '0;
      hold_q    <= '0;
      blink_q   <= '0;
      scan_q    <= '0;
      seg_sel_q <= '1;
      seg_dat_q <= 8'h00;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      edit_q    <= edit_d;
      tick_q    <= tick_d;
      hold_q    <= hold_d;
      blink_q   <= blink_d;
      scan_q    <= scan_d;
      seg_sel_q <= sel_d;
      seg_dat_q <= pat_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

`ifdef TIMER_COUNTUP_EN
  always_ff @(posedge clk_1khz) begin
    if (!nRst) begin
      target_q <= '0;
      up_q     <= 1'b0;
    end else begin
      target_q <= target_d;
      up_q     <= up_d;
    end
  end
`endif

  assign seg_dat  = seg_dat_q;
  assign seg_sel  = seg_sel_q;
  assign edit_idx = edit_q;
  assign running  = running_q;
  assign done     = done_q;

endmodule

// File: tb/tb_countdown_timer_n.sv
// tb/tb_countdown_timer_n.sv - directed self-checking bench for countdown_timer_n

module tb_countdown_timer_n;

  localparam int N = 4;

  localparam logic [7:0] S0 = 8'h3F;
  localparam logic [7:0] S1 = 8'h06;
  localparam logic [7:0] S2 = 8'h5B;
  localparam logic [7:0] S3 = 8'h4F;
  localparam logic [7:0] S4 = 8'h66;
  localparam logic [7:0] S5 = 8'h6D;
  localparam logic [7:0] S9 = 8'h67;

  logic         clk_1khz = 1'b0;
  logic         nRst     = 1'b0;
  logic         inc_p    = 1'b0;
  logic         next_p   = 1'b0;
  logic         pause_p  = 1'b0;
`ifdef TIMER_COUNTUP_EN
  logic         dir_up   = 1'b0;
`endif
  logic [7:0]   seg_dat;
  logic [N-1:0] seg_sel;
  logic [1:0]   edit_idx;
  logic         running;
  logic         done;

  int total = 0;
  int bad   = 0;

  // Per-position OR / AND of every pattern seen during a capture window:
  // a steady digit has or == and, a blinking digit has and == 00.
  logic [7:0] cap_or  [N];
  logic [7:0] cap_and [N];

  countdown_timer_n #(
    .NUM_DIGITS(4),
    .TICK_DIV  (100),
    .BLINK_HALF(50),
    .DONE_HOLD (2000)
  ) dut (
    .clk_1khz(clk_1khz),
    .nRst    (nRst),
    .inc_p   (inc_p),
    .next_p  (next_p),
    .pause_p (pause_p),
`ifdef TIMER_COUNTUP_EN
    .dir_up  (dir_up),
`endif
    .seg_dat (seg_dat),
    .seg_sel (seg_sel),
    .edit_idx(edit_idx),
    .running (running),
    .done    (done)
  );

  always #5 clk_1khz = ~clk_1khz;

  task automatic step(input int n);
    repeat (n) @(negedge clk_1khz);
  endtask

  task automatic pulse(input logic i, input logic n, input logic p);
    inc_p   = i;
    next_p  = n;
    pause_p = p;
    @(negedge clk_1khz);
    inc_p   = 1'b0;
    next_p  = 1'b0;
    pause_p = 1'b0;
  endtask

  task automatic capture(input int ncyc);
    logic [N-1:0] msb;
    msb      = '0;
    msb[N-1] = 1'b1;
    for (int p = 0; p < N; p++) begin
      cap_or[p]  = 8'h00;
      cap_and[p] = 8'hFF;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_1khz);
      for (int p = 0; p < N; p++) begin
        if (seg_sel == ~(msb >> p)) begin
          cap_or[p]  = cap_or[p] | seg_dat;
          cap_and[p] = cap_and[p] & seg_dat;
        end
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] seq [4];
    seq = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    nRst = 1'b0;
    step(2);
    total++; if (seg_sel !== 4'b1111) begin bad++; $display("FAIL reset_sel: got %b want 1111", seg_sel); end
    total++; if (seg_dat !== 8'h00) begin bad++; $display("FAIL reset_dat: got %h want 00", seg_dat); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running: got %b want 0", running); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (edit_idx !== 2'd0) begin bad++; $display("FAIL reset_edit: got %0d want 0", edit_idx); end
    nRst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_1khz);
      total++; if (seg_sel !== seq[k % 4]) begin bad++; $display("FAIL scan_sel[%0d]: got %b want %b", k, seg_sel, seq[k % 4]); end
      total++; if (seg_dat !== S0) begin bad++; $display("FAIL scan_dat[%0d]: got %h want %h", k, seg_dat, S0); end
    end
  endtask

  task automatic test_inc_wrap;
    repeat (3) pulse(1'b1, 1'b0, 1'b0);
    capture(100);
    total++; if (cap_or[0] !== S3) begin bad++; $display("FAIL inc3_digit0: got %h want %h", cap_or[0], S3); end
    total++; if (cap_and[0] !== 8'h00) begin bad++; $display("FAIL inc3_blink: got %h want 00", cap_and[0]); end
    for (int p = 1; p < N; p++) begin
      total++; if (cap_and[p] !== S0) begin bad++; $display("FAIL inc3_steady[%0d]: got %h want %h", p, cap_and[p], S0); end
    end
    repeat (7) pulse(1'b1, 1'b0, 1'b0);
    capture(100);
    total++; if (cap_or[0] !== S0) begin bad++; $display("FAIL inc_wrap: got %h want %h", cap_or[0], S0); end
    total++; if (edit_idx !== 2'd0) begin bad++; $display("FAIL inc_wrap_edit: got %0d want 0", edit_idx); end
  endtask

  task automatic test_zero_reject;
    repeat (3) pulse(1'b0, 1'b1, 1'b0);
    total++; if (edit_idx !== 2'd3) begin bad++; $display("FAIL zero_edit3: got %0d want 3", edit_idx); end
    pulse(1'b0, 1'b1, 1'b0);
    total++; if (edit_idx !== 2'd0) begin bad++; $display("FAIL zero_edit_back: got %0d want 0", edit_idx); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL zero_running: got %b want 0", running); end
    step(3);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL zero_running_later: got %b want 0", running); end
  endtask

  task automatic test_countdown;
    logic [7:0] want [4];
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    capture(100);
    want = '{S0, S0, S1, S2};
    for (int p = 0; p < N; p++) begin
      total++; if (cap_or[p] !== want[p]) begin bad++; $display("FAIL prog0012[%0d]: got %h want %h", p, cap_or[p], want[p]); end
    end
    total++; if (cap_and[3] !== 8'h00) begin bad++; $display("FAIL prog0012_blink: got %h want 00", cap_and[3]); end
    pulse(1'b0, 1'b1, 1'b0);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL start_running: got %b want 1", running); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL start_done: got %b want 0", done); end
    step(100);
    capture(4);
    want = '{S0, S0, S1, S1};
    for (int p = 0; p < N; p++) begin
      total++; if (cap_and[p] !== want[p]) begin bad++; $display("FAIL val0011[%0d]: got %h want %h", p, cap_and[p], want[p]); end
    end
    step(1095);
    total++; if (done !== 1'b0 || running !== 1'b1) begin bad++; $display("FAIL before_expiry: got done=%b running=%b want done=0 running=1", done, running); end
    step(1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL expiry_done: got %b want 1", done); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL expiry_running: got %b want 0", running); end
    capture(100);
    for (int p = 0; p < N; p++) begin
      total++; if (cap_or[p] !== S0 || cap_and[p] !== 8'h00) begin bad++; $display("FAIL done_blink[%0d]: got or=%h and=%h want or=%h and=00", p, cap_or[p], cap_and[p], S0); end
    end
    step(1899);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_hold: got %b want 1", done); end
    step(1);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_timeout: got %b want 0", done); end
    total++; if (edit_idx !== 2'd0 || running !== 1'b0) begin bad++; $display("FAIL done_timeout_set: got edit=%0d running=%b want edit=0 running=0", edit_idx, running); end
  endtask

  task automatic test_inc_next_same;
    repeat (3) pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL incnext_start: got %b want 1", running); end
    step(99);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL incnext_early: got %b want 0", done); end
    step(1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL incnext_done: got %b want 1", done); end
    pulse(1'b1, 1'b0, 1'b0);
    total++; if (done !== 1'b0 || edit_idx !== 2'd0) begin bad++; $display("FAIL ack_inc: got done=%b edit=%0d want done=0 edit=0", done, edit_idx); end
    capture(100);
    for (int p = 0; p < N; p++) begin
      total++; if (cap_or[p] !== S0) begin bad++; $display("FAIL ack_cleared[%0d]: got %h want %h", p, cap_or[p], S0); end
    end
  endtask

  task automatic test_borrow;
    logic [7:0] want [4];
    want = '{S0, S9, S9, S9};
    pulse(1'b1, 1'b0, 1'b0);
    repeat (3) pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL borrow_start: got %b want 1", running); end
    step(100);
    capture(4);
    for (int p = 0; p < N; p++) begin
      total++; if (cap_and[p] !== want[p]) begin bad++; $display("FAIL borrow0999[%0d]: got %h want %h", p, cap_and[p], want[p]); end
    end
    pulse(1'b0, 1'b0, 1'b1);
    total++; if (running !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL pause_flags: got running=%b done=%b want 0 0", running, done); end
    capture(100);
    for (int p = 0; p < N; p++) begin
      total++; if (cap_or[p] !== want[p] || cap_and[p] !== 8'h00) begin bad++; $display("FAIL pause_blink[%0d]: got or=%h and=%h want or=%h and=00", p, cap_or[p], cap_and[p], want[p]); end
    end
    pulse(1'b0, 1'b1, 1'b0);
    total++; if (running !== 1'b0 || edit_idx !== 2'd0) begin bad++; $display("FAIL abort: got running=%b edit=%0d want 0 0", running, edit_idx); end
    capture(100);
    total++; if (cap_or[0] !== S0 || cap_and[0] !== 8'h00) begin bad++; $display("FAIL abort_digit0: got or=%h and=%h want or=%h and=00", cap_or[0], cap_and[0], S0); end
    for (int p = 1; p < N; p++) begin
      total++; if (cap_and[p] !== S9) begin bad++; $display("FAIL abort_kept[%0d]: got %h want %h", p, cap_and[p], S9); end
    end
  endtask

  task automatic test_pause;
    nRst = 1'b0;
    step(1);
    nRst = 1'b1;
    repeat (3) pulse(1'b0, 1'b1, 1'b0);
    repeat (5) pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    step(49);
    pulse(1'b0, 1'b0, 1'b1);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_enter: got %b want 0", running); end
    capture(600);
    total++; if (cap_or[3] !== S5) begin bad++; $display("FAIL pause_hold: got %h want %h", cap_or[3], S5); end
    for (int p = 0; p < N; p++) begin
      total++; if (cap_and[p] !== 8'h00) begin bad++; $display("FAIL pause_all_blink[%0d]: got %h want 00", p, cap_and[p]); end
    end
    pulse(1'b0, 1'b0, 1'b1);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL resume: got %b want 1", running); end
    step(45);
    capture(4);
    total++; if (cap_and[3] !== S5 || cap_or[3] !== S5) begin bad++; $display("FAIL resume_before: got or=%h and=%h want %h", cap_or[3], cap_and[3], S5); end
    step(1);
    capture(4);
    total++; if (cap_and[3] !== S4 || cap_or[3] !== S4) begin bad++; $display("FAIL resume_after: got or=%h and=%h want %h", cap_or[3], cap_and[3], S4); end
    pulse(1'b0, 1'b1, 1'b1);
    total++; if (running !== 1'b0 || edit_idx !== 2'd0) begin bad++; $display("FAIL pause_wins: got running=%b edit=%0d want 0 0", running, edit_idx); end
    capture(100);
    for (int p = 0; p < N; p++) begin
      total++; if (cap_and[p] !== 8'h00) begin bad++; $display("FAIL pause_wins_blink[%0d]: got %h want 00", p, cap_and[p]); end
    end
    pulse(1'b0, 1'b0, 1'b1);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL pause_wins_resume: got %b want 1", running); end
  endtask

  task automatic test_reset_mid_run;
    nRst = 1'b0;
    step(1);
    total++; if (seg_sel !== 4'b1111 || seg_dat !== 8'h00) begin bad++; $display("FAIL run_reset_disp: got sel=%b dat=%h want 1111 00", seg_sel, seg_dat); end
    total++; if (running !== 1'b0 || done !== 1'b0 || edit_idx !== 2'd0) begin bad++; $display("FAIL run_reset_flags: got running=%b done=%b edit=%0d want 0 0 0", running, done, edit_idx); end
    nRst = 1'b1;
    capture(100);
    total++; if (cap_or[0] !== S0 || cap_and[0] !== 8'h00) begin bad++; $display("FAIL run_reset_d0: got or=%h and=%h want or=%h and=00", cap_or[0], cap_and[0], S0); end
    for (int p = 1; p < N; p++) begin
      total++; if (cap_and[p] !== S0) begin bad++; $display("FAIL run_reset_digits[%0d]: got %h want %h", p, cap_and[p], S0); end
    end
  endtask

  task automatic test_reset_mid_done;
    repeat (3) pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    step(100);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_again: got %b want 1", done); end
    nRst = 1'b0;
    step(1);
    total++; if (done !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL done_reset_flags: got done=%b running=%b want 0 0", done, running); end
    total++; if (seg_sel !== 4'b1111 || seg_dat !== 8'h00) begin bad++; $display("FAIL done_reset_disp: got sel=%b dat=%h want 1111 00", seg_sel, seg_dat); end
    nRst = 1'b1;
    capture(100);
    for (int p = 0; p < N; p++) begin
      total++; if (cap_or[p] !== S0) begin bad++; $display("FAIL done_reset_digits[%0d]: got %h want %h", p, cap_or[p], S0); end
    end
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_zero_reject();
    test_countdown();
    test_inc_next_same();
    test_borrow();
    test_pause();
    test_reset_mid_run();
    test_reset_mid_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
